// File: rtl/fft_digit_reverse_if.sv
// Sample stream bundle between an upstream radix-4 SDF FFT, the digit-reverse
// reorder buffer and the downstream consumer.
interface fft_digit_reverse_if #(
    parameter int WIDTH = 32
);
    logic             input_en;
    logic [WIDTH-1:0] input_real;
    logic [WIDTH-1:0] input_imag;
    logic             output_en;
    logic             output_sof;
    logic [WIDTH-1:0] output_real;
    logic [WIDTH-1:0] output_imag;

    modport master (
        output input_en, input_real, input_imag,
        input  output_en, output_sof, output_real, output_imag
    );

    modport slave (
        input  input_en, input_real, input_imag,
        output output_en, output_sof, output_real, output_imag
    );
endinterface

// File: rtl/fft_digit_reverse.sv
// Ping-pong reorder buffer: frames arrive in base-4 digit-reversed order and
// leave in natural frequency order, back-to-back when the next frame is ready.
module fft_digit_reverse #(
    parameter int WIDTH = 32,
    parameter int N     = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    fft_digit_reverse_if.slave   bus
);
    localparam int            AW     = $clog2(N);
    localparam int            DIGITS = AW / 2;
    localparam logic [AW-1:0] LAST   = AW'(N - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    // Reverse the order of the 2-bit base-4 digits of a sample index.
    function automatic logic [AW-1:0] digit_rev(input logic [AW-1:0] idx);
        logic [AW-1:0] rev;
        rev = '0;
        for (int d = 0; d < DIGITS; d++) begin
            rev[2*d +: 2] = idx[AW-2-2*d +: 2];
        end
        return rev;
    endfunction

    logic [AW-1:0]      wr_cnt_r;
    logic               wr_bank_r;
    logic [AW-1:0]      rd_cnt_r;
    logic [AW-1:0]      rd_cnt_nxt_s;
    logic               rd_bank_r;
    logic               rd_bank_nxt_s;
    logic [1:0]         ready_r;
    logic [1:0]         ready_nxt_s;
    logic [0:0]         state_r;
    logic [0:0]         state_nxt_s;
    logic               frame_done_s;
    logic               start_s;
    logic               start_bank_s;
    logic               other_ready_s;
    logic [AW:0]        rd_addr_s;
    logic [2*WIDTH-1:0] rd_word_s;
    logic [2*WIDTH-1:0] mem_r [0:2*N-1];

    logic               out_en_r;
    logic               out_sof_r;
    logic [WIDTH-1:0]   out_real_r;
    logic [WIDTH-1:0]   out_imag_r;

    assign frame_done_s = bus.input_en && (wr_cnt_r == LAST);
    assign rd_addr_s    = {rd_bank_r, digit_rev(rd_cnt_r)};
    assign rd_word_s    = mem_r[rd_addr_s];

    // Read FSM next-state: a read starts on frame completion, and chains into
    // the other bank at the last read cycle if that bank is (or just became) ready.
    always_comb begin
        state_nxt_s   = state_r;
        rd_cnt_nxt_s  = rd_cnt_r;
        rd_bank_nxt_s = rd_bank_r;
        start_s       = 1'b0;
        start_bank_s  = wr_bank_r;
        other_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_done_s) begin
                    state_nxt_s   = ST_READ;
                    rd_cnt_nxt_s  = '0;
                    rd_bank_nxt_s = wr_bank_r;
                    start_s       = 1'b1;
                    start_bank_s  = wr_bank_r;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_cnt_nxt_s = rd_cnt_r + 1'b1;
                if (rd_cnt_r == LAST) begin
                    other_ready_s = ready_r[~rd_bank_r] ||
                                    (frame_done_s && (wr_bank_r != rd_bank_r));
                    if (other_ready_s) begin
                        state_nxt_s   = ST_READ;
                        rd_cnt_nxt_s  = '0;
                        rd_bank_nxt_s = ~rd_bank_r;
                        start_s       = 1'b1;
                        start_bank_s  = ~rd_bank_r;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Ready marks: set when a bank fills, cleared when its read starts.
    always_comb begin
        ready_nxt_s = ready_r;
        if (frame_done_s) begin
            ready_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            ready_nxt_s[wr_bank_r] = ready_r[wr_bank_r];
        end
        if (start_s) begin
            ready_nxt_s[start_bank_s] = 1'b0;
        end else begin
            ready_nxt_s[start_bank_s] = ready_nxt_s[start_bank_s];
        end
    end

    // Control state: write pointer, bank selects, ready marks and read FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            wr_cnt_r  <= '0;
            wr_bank_r <= 1'b0;
            rd_cnt_r  <= '0;
            rd_bank_r <= 1'b0;
            ready_r   <= 2'b00;
        end else begin
            state_r   <= state_nxt_s;
            rd_cnt_r  <= rd_cnt_nxt_s;
            rd_bank_r <= rd_bank_nxt_s;
            ready_r   <= ready_nxt_s;
            if (bus.input_en) begin
                wr_cnt_r <= wr_cnt_r + 1'b1;
                if (frame_done_s) begin
                    wr_bank_r <= ~wr_bank_r;
                end
            end
        end
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (bus.input_en) begin
            mem_r[{wr_bank_r, wr_cnt_r}] <= {bus.input_real, bus.input_imag};
        end
    end

    // Registered read port; data and sof are forced to zero outside a burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_en_r   <= 1'b0;
            out_sof_r  <= 1'b0;
            out_real_r <= '0;
            out_imag_r <= '0;
        end else if (state_r == ST_READ) begin
            out_en_r   <= 1'b1;
            out_sof_r  <= (rd_cnt_r == '0);
            out_real_r <= rd_word_s[2*WIDTH-1:WIDTH];
            out_imag_r <= rd_word_s[WIDTH-1:0];
        end else begin
            out_en_r   <= 1'b0;
            out_sof_r  <= 1'b0;
            out_real_r <= '0;
            out_imag_r <= '0;
        end
    end

    assign bus.output_en   = out_en_r;
    assign bus.output_sof  = out_sof_r;
    assign bus.output_real = out_real_r;
    assign bus.output_imag = out_imag_r;
endmodule

// File: tb/tb_fft_digit_reverse.sv
// Scoreboard bench for fft_digit_reverse with N=16: each completed input frame
// pushes its naturally ordered output samples; outputs are popped and compared.
module tb_fft_digit_reverse;
    localparam int WIDTH = 32;
    localparam int N     = 16;

    typedef struct packed {
        logic             sof;
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } smp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fft_digit_reverse_if #(.WIDTH(WIDTH)) bus ();

    fft_digit_reverse #(.WIDTH(WIDTH), .N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    smp_t             sb[$];
    logic [WIDTH-1:0] fr_re[N];
    logic [WIDTH-1:0] fr_im[N];
    int               fill;
    int               checks;
    int               errors;

    // Natural-order bin j of a 16-point frame sits at input position (j%4)*4 + j/4.
    function automatic int rev_idx(input int j);
        return (j % 4) * 4 + (j / 4);
    endfunction

    // Drive one cycle of input, update the frame model, land 1 time unit past the edge.
    task automatic step(input logic en, input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        smp_t e;
        bus.input_en   = en;
        bus.input_real = re;
        bus.input_imag = im;
        if (en) begin
            fr_re[fill] = re;
            fr_im[fill] = im;
            fill++;
            if (fill == N) begin
                for (int j = 0; j < N; j++) begin
                    e.sof = (j == 0);
                    e.re  = fr_re[rev_idx(j)];
                    e.im  = fr_im[rev_idx(j)];
                    sb.push_back(e);
                end
                fill = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, '0, '0);
        reset = 1'b0;
        fill  = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        smp_t got;
        do_reset();
        got = {bus.output_sof, bus.output_real, bus.output_imag};
        checks++;
        if (bus.output_en !== 1'b0 || got !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b %h want en=0 all zero", bus.output_en, got);
        end
    endtask

    task automatic test_single_frame();
        smp_t got, e;
        logic exp_en;
        for (int c = 0; c < 2*N + 2; c++) begin
            if (c < N) step(1'b1, WIDTH'(c), WIDTH'(100 + c));
            else       step(1'b0, '0, '0);
            exp_en = (c >= N) && (c < 2*N);
            got    = {bus.output_sof, bus.output_real, bus.output_imag};
            checks++;
            if (bus.output_en !== exp_en) begin
                errors++;
                $display("FAIL single_en c=%0d: got %b want %b", c, bus.output_en, exp_en);
            end
            if (exp_en) begin
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL single_data c=%0d: got %h want %h", c, got, e);
                end
            end else if (c >= N) begin
                checks++;
                if (got !== '0) begin
                    errors++;
                    $display("FAIL single_idle_zero c=%0d: got %h want 0", c, got);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_leftover: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        smp_t got, e;
        logic exp_en;
        for (int c = 0; c < 4*N + 2; c++) begin
            if (c < 3*N) step(1'b1, WIDTH'(1000 * (c / N) + c % N), WIDTH'(32'h5000 + 7 * c));
            else         step(1'b0, '0, '0);
            exp_en = (c >= N) && (c < 4*N);
            got    = {bus.output_sof, bus.output_real, bus.output_imag};
            checks++;
            if (bus.output_en !== exp_en) begin
                errors++;
                $display("FAIL b2b_en c=%0d: got %b want %b", c, bus.output_en, exp_en);
            end
            if (exp_en && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL b2b_data c=%0d: got %h want %h", c, got, e);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_gapped_input();
        smp_t got, e;
        logic exp_en;
        for (int c = 0; c < 3*N + 1; c++) begin
            if (c < 2*N && c % 2 == 0) step(1'b1, WIDTH'(c / 2), WIDTH'(100 + c / 2));
            else                       step(1'b0, '0, '0);
            exp_en = (c >= 2*N - 1) && (c < 3*N - 1);
            got    = {bus.output_sof, bus.output_real, bus.output_imag};
            checks++;
            if (bus.output_en !== exp_en) begin
                errors++;
                $display("FAIL gap_en c=%0d: got %b want %b", c, bus.output_en, exp_en);
            end
            if (exp_en && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL gap_data c=%0d: got %h want %h", c, got, e);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL gap_leftover: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_reset_partial_input();
        smp_t got, e;
        logic exp_en;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, WIDTH'(32'hA00 + c), WIDTH'(32'hB00 + c));
        end
        do_reset();
        for (int c = 0; c < 2*N + 2; c++) begin
            if (c < N) step(1'b1, WIDTH'(500 + c), WIDTH'(900 + c));
            else       step(1'b0, '0, '0);
            exp_en = (c >= N) && (c < 2*N);
            got    = {bus.output_sof, bus.output_real, bus.output_imag};
            checks++;
            if (bus.output_en !== exp_en) begin
                errors++;
                $display("FAIL partial_en c=%0d: got %b want %b", c, bus.output_en, exp_en);
            end
            if (exp_en && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL partial_data c=%0d: got %h want %h", c, got, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_output();
        smp_t got, e;
        logic exp_en;
        for (int c = 0; c < N + 6; c++) begin
            if (c < N) step(1'b1, WIDTH'(40 + c), WIDTH'(80 + c));
            else       step(1'b0, '0, '0);
            exp_en = (c >= N);
            got    = {bus.output_sof, bus.output_real, bus.output_imag};
            checks++;
            if (bus.output_en !== exp_en) begin
                errors++;
                $display("FAIL midrst_en c=%0d: got %b want %b", c, bus.output_en, exp_en);
            end
            if (exp_en && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL midrst_data c=%0d: got %h want %h", c, got, e);
                end
            end
        end
        do_reset();
        for (int c = 0; c < 2*N; c++) begin
            got = {bus.output_sof, bus.output_real, bus.output_imag};
            checks++;
            if (bus.output_en !== 1'b0 || got !== '0) begin
                errors++;
                $display("FAIL midrst_quiet c=%0d: got en=%b %h want en=0 all zero", c, bus.output_en, got);
            end
            step(1'b0, '0, '0);
        end
    endtask

    task automatic test_extreme_values();
        smp_t got, e;
        logic exp_en;
        logic [WIDTH-1:0] re, im;
        for (int c = 0; c < 2*N + 1; c++) begin
            case (c % 4)
                0:       begin re = 32'h8000_0000; im = 32'hFFFF_FFFF; end
                1:       begin re = 32'hFFFF_FFFF; im = 32'h8000_0000; end
                2:       begin re = 32'h8000_0000; im = 32'h8000_0000; end
                default: begin re = 32'hFFFF_FFFF; im = WIDTH'(c); end
            endcase
            if (c < N) step(1'b1, re, im);
            else       step(1'b0, '0, '0);
            exp_en = (c >= N) && (c < 2*N);
            got    = {bus.output_sof, bus.output_real, bus.output_imag};
            checks++;
            if (bus.output_en !== exp_en) begin
                errors++;
                $display("FAIL extreme_en c=%0d: got %b want %b", c, bus.output_en, exp_en);
            end
            if (exp_en && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL extreme_data c=%0d: got %h want %h", c, got, e);
                end
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        fill           = 0;
        reset          = 1'b1;
        bus.input_en   = 1'b0;
        bus.input_real = '0;
        bus.input_imag = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped_input();
        test_reset_partial_input();
        test_reset_mid_output();
        test_extreme_values();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_digit_reverse.md
FFT_DIGIT_REVERSE -- requirements
Module: fft_digit_reverse

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each of the real and imaginary sample words.
REQ-002 Parameter N, default 256: frame length in samples; SHALL be a power of 4 and at least 4.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 input_en  input  1  input sample valid; driven by the output_en of the upstream radix-4 SDF FFT.
REQ-006 input_real  input  WIDTH  real part of the input sample, in base-4 digit-reversed frame order.
REQ-007 input_imag  input  WIDTH  imaginary part of the input sample.
REQ-008 output_en  output  1  output sample valid.
REQ-009 output_real  output  WIDTH  real part of the output sample, in natural frequency order.
REQ-010 output_imag  output  WIDTH  imaginary part of the output sample.
REQ-011 output_sof  output  1  high together with output_en on the first sample (bin 0) of each output frame.

Function
REQ-012 Storage SHALL be two banks (ping-pong), each holding N complex words; there is no backpressure.
REQ-013 Write side: a sample is accepted on every edge with input_en=1.
- Write address = wr_cnt (0..N-1) in bank wr_bank.
- wr_cnt increments by 1 per accepted sample; gaps in input_en hold wr_cnt.
REQ-014 Frame-complete event: the edge that writes wr_cnt=N-1.
- At that edge: wr_cnt wraps to 0, wr_bank toggles, and the completed bank is marked ready.
REQ-015 Read FSM SHALL have two states, IDLE and READ.
- IDLE->READ at a frame-complete edge: rd_cnt<=0, rd_bank<=completed bank.
- READ: rd_cnt increments by 1 every cycle, irrespective of input_en.
REQ-016 Read address = digit_rev(rd_cnt): the log4(N) base-4 digits (2-bit fields) of rd_cnt in reversed order, e.g. N=16: rd_cnt 1 -> address 4, rd_cnt 6 -> address 9.
REQ-017 Read data SHALL be registered: output_en, output_sof, output_real and output_imag are valid in the cycle after the read address is issued.
- Frame latency: the first output_en is high 2 cycles after the cycle presenting input sample N-1.
REQ-018 At the READ edge with rd_cnt=N-1:
- If the other bank is ready (including readiness set at this same edge), stay in READ with rd_cnt<=0 and rd_bank toggled, so output is seamless and back-to-back.
- Otherwise go to IDLE.
REQ-019 Each output frame SHALL have exactly N consecutive output_en cycles; output_sof is high exactly once, on the rd_cnt=0 sample.
REQ-020 When output_en=0: output_real, output_imag and output_sof SHALL be 0.
REQ-021 Data SHALL pass bit-exact: no scaling, rounding or sign change.
REQ-022 Simultaneous write and read of the same bank cannot occur for input rates up to 1 sample/cycle; no collision logic is required.
REQ-023 A bank's ready mark SHALL clear when its read starts.

Reset
REQ-024 Reset clears wr_cnt, rd_cnt, wr_bank, rd_bank and the ready marks; the FSM goes to IDLE.
REQ-025 After reset: output_en=0, output_sof=0, output_real=0 and output_imag=0 from the first cycle following the reset edge.
REQ-026 A partial input frame or an in-progress output frame at reset SHALL be discarded, with no further output from it.
REQ-027 Memory contents need not be reset.

Verification (N=16, WIDTH=32)
REQ-028 One frame: input_real=k, input_imag=100+k for k=0..15, contiguous.
- Required: output_real sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; output_imag = output_real+100.
- First output_en 2 cycles after k=15 is presented; output_sof only on the first output.
REQ-029 Three back-to-back frames with contiguous input_en.
- Required: 48 contiguous output_en cycles, output_sof at output samples 0, 16 and 32, each frame correctly reordered.
REQ-030 One frame with input_en toggling 1,0,1,0,...
- Required: identical output order to REQ-028; output_en is a contiguous 16-cycle burst starting 2 cycles after the last input.
REQ-031 Reset asserted for one cycle after 8 samples of frame A, then a full frame B.
- Required: no output for frame A; frame B is output correctly.
REQ-032 Reset asserted at output sample 5 of a frame.
- Required: output_en=0 and all data outputs=0 the cycle after the reset edge; no remaining samples of that frame appear.
REQ-033 Values 32'h8000_0000 and 32'hFFFF_FFFF on both input_real and input_imag.
- Required: reproduced bit-exact at the digit-reversed positions.
